// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples an active-low, time-multiplexed 7-segment bus
// (segment lines plus per-digit enables) and decodes it back into hex digits.
// Each digit must be seen unchanged for STABLE_CNT synchronized samples before
// it is committed. A frame is published once every digit has been committed.
// Optional feature macro: SEG7_SCAN_DP_EN adds the decimal point input dp_in_n
// and the per-digit output dp_out. The dp bit becomes part of the compared pattern.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en_n,
`ifdef SEG7_SCAN_DP_EN
    input  logic                    dp_in_n,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic                    frame_valid
);

`ifdef SEG7_SCAN_DP_EN
    localparam int PW = 8;   // {dp, g..a}
`else
    localparam int PW = 7;   // {g..a}
`endif

    localparam logic [7:0] STABLE_CNT_C = 8'(STABLE_CNT);

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HELD} state_t;

    // Returns {err, blank, value[3:0]} for an active-low segment pattern.
    function automatic logic [5:0] dec7(input logic [6:0] p);
        case (p)
            7'b1000000: dec7 = {2'b00, 4'h0};
            7'b1111001: dec7 = {2'b00, 4'h1};
            7'b0100100: dec7 = {2'b00, 4'h2};
            7'b0110000: dec7 = {2'b00, 4'h3};
            7'b0011001: dec7 = {2'b00, 4'h4};
            7'b0010010: dec7 = {2'b00, 4'h5};
            7'b0000010: dec7 = {2'b00, 4'h6};
            7'b1111000: dec7 = {2'b00, 4'h7};
            7'b0000000: dec7 = {2'b00, 4'h8};
            7'b0010000: dec7 = {2'b00, 4'h9};
            7'b0001000: dec7 = {2'b00, 4'hA};
            7'b0000011: dec7 = {2'b00, 4'hB};
            7'b1000110: dec7 = {2'b00, 4'hC};
            7'b0100001: dec7 = {2'b00, 4'hD};
            7'b0000110: dec7 = {2'b00, 4'hE};
            7'b0001110: dec7 = {2'b00, 4'hF};
            7'b1111111: dec7 = {2'b01, 4'h0};
            default:    dec7 = {2'b10, 4'h0};
        endcase
    endfunction

    logic [PW-1:0]           w_pat_in;
    logic [PW-1:0]           r_seg_s1, r_seg_s2;
    logic [NUM_DIGITS-1:0]   r_en_s1, r_en_s2;

    state_t                  r_state, w_state_nxt;
    logic [7:0]              r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [PW-1:0]           r_cur_pat, w_cur_pat_nxt;
    logic [NUM_DIGITS-1:0]   r_cur_en, w_cur_en_nxt;
    logic                    w_commit;

    logic [NUM_DIGITS-1:0]   w_sel;
    logic                    w_valid;
    logic                    w_match;
    logic [5:0]              w_dec;
    logic [NUM_DIGITS-1:0]   w_commit_mask;

    logic [NUM_DIGITS-1:0]   r_seen;
    logic [4*NUM_DIGITS-1:0] r_sh_val, w_sh_val_nxt;
    logic [NUM_DIGITS-1:0]   r_sh_blank, w_sh_blank_nxt;
    logic [NUM_DIGITS-1:0]   r_sh_err, w_sh_err_nxt;
`ifdef SEG7_SCAN_DP_EN
    logic [NUM_DIGITS-1:0]   r_sh_dp, w_sh_dp_nxt;

    assign w_pat_in = {dp_in_n, seg_in};
`else
    assign w_pat_in = seg_in;
`endif

    // A sample belongs to a slot only when exactly one enable is asserted.
    assign w_sel   = ~r_en_s2;
    assign w_valid = (w_sel != '0) && ((w_sel & (w_sel - NUM_DIGITS'(1))) == '0);
    assign w_match = (r_en_s2 == r_cur_en) && (r_seg_s2 == r_cur_pat);
    assign w_cnt_inc = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
    assign w_dec = dec7(r_cur_pat[6:0]);
    assign w_commit_mask = w_commit ? ~r_cur_en : '0;

    // Two-flop synchronizers; idle value is all-ones (nothing lit, no digit).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_s1 <= '1;
            r_seg_s2 <= '1;
            r_en_s1  <= '1;
            r_en_s2  <= '1;
        end else begin
            r_seg_s1 <= w_pat_in;
            r_seg_s2 <= r_seg_s1;
            r_en_s1  <= dig_en_n;
            r_en_s2  <= r_en_s1;
        end
    end

    // Tracker state register with the current candidate slot/pattern and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_cur_pat <= '1;
            r_cur_en  <= '1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cur_pat <= w_cur_pat_nxt;
            r_cur_en  <= w_cur_en_nxt;
        end
    end

    // Tracker next-state: restart on any change, commit once on reaching the threshold.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cur_pat_nxt = r_cur_pat;
        w_cur_en_nxt  = r_cur_en;
        w_commit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_cur_pat_nxt = r_seg_s2;
                    w_cur_en_nxt  = r_en_s2;
                    w_cnt_nxt     = 8'd1;
                    w_state_nxt   = S_TRACK;
                end
            end
            S_TRACK: begin
                if (!w_valid) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_IDLE;
                end else if (w_match) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= STABLE_CNT_C) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_HELD;
                    end
                end else begin
                    w_cur_pat_nxt = r_seg_s2;
                    w_cur_en_nxt  = r_en_s2;
                    w_cnt_nxt     = 8'd1;
                end
            end
            S_HELD: begin
                if (!w_valid) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_IDLE;
                end else if (!w_match) begin
                    w_cur_pat_nxt = r_seg_s2;
                    w_cur_en_nxt  = r_en_s2;
                    w_cnt_nxt     = 8'd1;
                    w_state_nxt   = S_TRACK;
                end
            end
            default: begin
                w_cnt_nxt   = 8'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Shadow update: a commit overwrites its slot, later commits win.
    always_comb begin
        w_sh_val_nxt   = r_sh_val;
        w_sh_blank_nxt = r_sh_blank;
        w_sh_err_nxt   = r_sh_err;
`ifdef SEG7_SCAN_DP_EN
        w_sh_dp_nxt    = r_sh_dp;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_commit_mask[i]) begin
                w_sh_val_nxt[4*i +: 4] = w_dec[3:0];
                w_sh_blank_nxt[i]      = w_dec[4];
                w_sh_err_nxt[i]        = w_dec[5];
`ifdef SEG7_SCAN_DP_EN
                w_sh_dp_nxt[i]         = ~r_cur_pat[PW-1];
`endif
            end
        end
    end

    // Frame assembly: publish the shadow (including any same-cycle commit) once all slots are seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen      <= '0;
            r_sh_val    <= '0;
            r_sh_blank  <= '0;
            r_sh_err    <= '0;
            digits_out  <= '0;
            blank_out   <= '0;
            err_out     <= '0;
            frame_valid <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            r_sh_dp     <= '0;
            dp_out      <= '0;
`endif
        end else begin
            r_sh_val   <= w_sh_val_nxt;
            r_sh_blank <= w_sh_blank_nxt;
            r_sh_err   <= w_sh_err_nxt;
`ifdef SEG7_SCAN_DP_EN
            r_sh_dp    <= w_sh_dp_nxt;
`endif
            if (&r_seen) begin
                digits_out  <= w_sh_val_nxt;
                blank_out   <= w_sh_blank_nxt;
                err_out     <= w_sh_err_nxt;
`ifdef SEG7_SCAN_DP_EN
                dp_out      <= w_sh_dp_nxt;
`endif
                frame_valid <= 1'b1;
                r_seen      <= '0;
            end else begin
                frame_valid <= 1'b0;
                r_seen      <= r_seen | w_commit_mask;
            end
        end
    end

endmodule
